// File: rtl/memory_bus.sv
// CPU-side memory bus controller: decodes the 6502 address onto RAM, ROM and a small
// peripheral page behind an enable/done handshake. Define MEMORY_BUS_TRAP_EN for the bus_error trap.
module memory_bus #(
  parameter int         TICK_WIDTH     = 16,
  parameter logic [7:0] UNMAPPED_VALUE = 8'hff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  input  logic        cpu_bus_enable,
  input  logic        cpu_write,
  output logic        cpu_bus_done,
  output logic [9:0]  ram_address,
  output logic [7:0]  ram_data_in,
  input  logic [7:0]  ram_data_out,
  output logic        ram_write_enable,
  output logic [13:0] rom_address,
  input  logic [7:0]  rom_data_out,
  output logic [7:0]  leds,
  input  logic [3:0]  buttons,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_ROM,
    REG_LED,
    REG_BTN,
    REG_TICK_LO,
    REG_TICK_HI,
    REG_ERR
  } region_e;

  function automatic region_e decode(input logic [15:0] addr);
    region_e r;
    r = REG_NONE;
    if (addr[15:10] == 6'd0) begin
      r = REG_RAM;
    end else if (addr[15:14] == 2'b11) begin
      r = REG_ROM;
    end else begin
      case (addr)
        16'h4000: r = REG_LED;
        16'h4001: r = REG_BTN;
        16'h4002: r = REG_TICK_LO;
        16'h4003: r = REG_TICK_HI;
`ifdef MEMORY_BUS_TRAP_EN
        16'h4004: r = REG_ERR;
`endif
        default:  r = REG_NONE;
      endcase
    end
    return r;
  endfunction

  state_e                  state_q, state_d;
  region_e                 region_q, region_d;
  logic                    write_q, write_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [9:0]              ram_address_q, ram_address_d;
  logic [13:0]             rom_address_q, rom_address_d;
  logic                    ram_we_q, ram_we_d;
  logic                    done_q, done_d;
  logic [7:0]              data_out_q, data_out_d;
  logic [7:0]              leds_q, leds_d;
  logic [7:0]              hold_q, hold_d;
  logic [TICK_WIDTH-1:0]   tick_q, tick_d;
  logic [3:0]              sync1_q, sync1_d;
  logic [3:0]              sync2_q, sync2_d;
  logic [15:0]             tick_ext;
`ifdef MEMORY_BUS_TRAP_EN
  logic                    err_q, err_d;
`endif

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    region_d      = region_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    ram_address_d = ram_address_q;
    rom_address_d = rom_address_q;
    ram_we_d      = 1'b0;
    done_d        = done_q;
    data_out_d    = data_out_q;
    leds_d        = leds_q;
    hold_d        = hold_q;
    tick_d        = tick_q + TICK_WIDTH'(1);
    sync1_d       = buttons;
    sync2_d       = sync1_q;
`ifdef MEMORY_BUS_TRAP_EN
    err_d         = err_q;
`endif

    tick_ext                   = '0;
    tick_ext[TICK_WIDTH-1:0]   = tick_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_bus_enable) begin
          region_d      = decode(cpu_address);
          write_d       = cpu_write;
          wdata_d       = cpu_data_in;
          ram_address_d = cpu_address[9:0];
          rom_address_d = cpu_address[13:0];
          ram_we_d      = cpu_write && (decode(cpu_address) == REG_RAM);
          state_d       = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (write_q) begin
          case (region_q)
            REG_LED:     leds_d = wdata_q;
            REG_TICK_LO: tick_d = '0;
            default:     ;
          endcase
        end
`ifdef MEMORY_BUS_TRAP_EN
        // A ROM write is treated as an access to nothing.
        if (region_q == REG_NONE || (write_q && region_q == REG_ROM)) err_d = 1'b1;
        if (write_q && region_q == REG_ERR) err_d = 1'b0;
`endif
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        if (!write_q) begin
          case (region_q)
            REG_RAM:     data_out_d = ram_data_out;
            REG_ROM:     data_out_d = rom_data_out;
            REG_LED:     data_out_d = leds_q;
            REG_BTN:     data_out_d = {4'b0000, sync2_q};
            REG_TICK_LO: begin
              data_out_d = tick_ext[7:0];
              hold_d     = tick_ext[15:8];
            end
            REG_TICK_HI: data_out_d = hold_q;
`ifdef MEMORY_BUS_TRAP_EN
            REG_ERR:     data_out_d = {7'b0000000, err_q};
`endif
            default:     data_out_d = UNMAPPED_VALUE;
          endcase
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (!cpu_bus_enable) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q       <= S_IDLE;
      region_q      <= REG_NONE;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      ram_address_q <= '0;
      rom_address_q <= '0;
      ram_we_q      <= 1'b0;
      done_q        <= 1'b0;
      data_out_q    <= '0;
      leds_q        <= '0;
      hold_q        <= '0;
      tick_q        <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
`ifdef MEMORY_BUS_TRAP_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      region_q      <= region_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      ram_address_q <= ram_address_d;
      rom_address_q <= rom_address_d;
      ram_we_q      <= ram_we_d;
      done_q        <= done_d;
      data_out_q    <= data_out_d;
      leds_q        <= leds_d;
      hold_q        <= hold_d;
      tick_q        <= tick_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
`ifdef MEMORY_BUS_TRAP_EN
      err_q         <= err_d;
`endif
    end
  end

  // The RAM has no reset, so the strobe is masked by reset to drop a write caught mid-flight.
  assign ram_write_enable = ram_we_q & ~reset;
  assign ram_address      = ram_address_q;
  assign ram_data_in      = wdata_q;
  assign rom_address      = rom_address_q;
  assign cpu_data_out     = data_out_q;
  assign cpu_bus_done     = done_q;
  assign leds             = leds_q;
`ifdef MEMORY_BUS_TRAP_EN
  assign bus_error        = err_q;
`else
  assign bus_error        = 1'b0;
`endif

endmodule

// File: tb/tb_memory_bus.sv
// Directed self-checking bench for memory_bus with behavioural RAM/ROM models;
// expectations follow MEMORY_BUS_TRAP_EN when it is defined.
module tb_memory_bus;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_bus_enable;
  logic        cpu_write;
  logic        cpu_bus_done;
  logic [9:0]  ram_address;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;
  logic        ram_write_enable;
  logic [13:0] rom_address;
  logic [7:0]  rom_data_out;
  logic [7:0]  leds;
  logic [3:0]  buttons;
  logic        bus_error;

  memory_bus dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_address      (cpu_address),
    .cpu_data_in      (cpu_data_in),
    .cpu_data_out     (cpu_data_out),
    .cpu_bus_enable   (cpu_bus_enable),
    .cpu_write        (cpu_write),
    .cpu_bus_done     (cpu_bus_done),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out),
    .ram_write_enable (ram_write_enable),
    .rom_address      (rom_address),
    .rom_data_out     (rom_data_out),
    .leds             (leds),
    .buttons          (buttons),
    .bus_error        (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram_mem [0:1023];
  logic       mem_clear;
  int         we_count;
  logic [9:0] last_we_addr;
  logic [7:0] last_we_data;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= 8'h00;
    end else if (ram_write_enable) begin
      ram_mem[ram_address] <= ram_data_in;
    end
    ram_data_out <= ram_mem[ram_address];
    rom_data_out <= rom_address[7:0];
  end

  always @(posedge clk) begin
    if (ram_write_enable) begin
      we_count     <= we_count + 1;
      last_we_addr <= ram_address;
      last_we_data <= ram_data_in;
    end
  end

  int n_total;
  int n_pass;
  int n_fail;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [15:0] a, input logic w, input logic [7:0] d);
    cpu_address    = a;
    cpu_write      = w;
    cpu_data_in    = d;
    cpu_bus_enable = 1'b1;
  endtask

  // Counts edges after the acceptance edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    @(posedge clk);
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!cpu_bus_done && lat < 20);
  endtask

  task automatic end_req(input string tag);
    cpu_bus_enable = 1'b0;
    @(negedge clk);
    check({tag, "_done_low"}, 16'(cpu_bus_done), 16'h0);
  endtask

  task automatic access(input string tag, input logic [15:0] a, input logic w,
                        input logic [7:0] d, output logic [7:0] rd);
    int lat;
    start_req(a, w, d);
    wait_done(lat);
    check({tag, "_lat"}, 16'(lat), 16'd2);
    rd = cpu_data_out;
    end_req(tag);
  endtask

  initial begin
    logic [7:0] rd;
    int         w0;
    int         lat;
    logic       ok;

    n_total        = 0;
    n_pass         = 0;
    n_fail         = 0;
    we_count       = 0;
    reset          = 1'b1;
    mem_clear      = 1'b1;
    cpu_address    = 16'h0;
    cpu_data_in    = 8'h0;
    cpu_write      = 1'b0;
    cpu_bus_enable = 1'b0;
    buttons        = 4'h0;

    repeat (3) @(negedge clk);
    check("rst_done",     16'(cpu_bus_done),     16'h0);
    check("rst_dout",     16'(cpu_data_out),     16'h0);
    check("rst_we",       16'(ram_write_enable), 16'h0);
    check("rst_ram_addr", 16'(ram_address),      16'h0);
    check("rst_rom_addr", 16'(rom_address),      16'h0);
    check("rst_ram_din",  16'(ram_data_in),      16'h0);
    check("rst_leds",     16'(leds),             16'h0);
    check("rst_err",      16'(bus_error),        16'h0);
    reset     = 1'b0;
    mem_clear = 1'b0;
    @(negedge clk);

    // RAM write then read back
    w0 = we_count;
    access("ram_wr", 16'h0123, 1'b1, 8'h5A, rd);
    check("ram_wr_strobes", 16'(we_count - w0), 16'd1);
    check("ram_wr_addr",    16'(last_we_addr),  16'h0123);
    check("ram_wr_data",    16'(last_we_data),  16'h005A);
    check("ram_wr_dout",    16'(rd),            16'h0000);
    access("ram_rd", 16'h0123, 1'b0, 8'h00, rd);
    check("ram_rd_data", 16'(rd), 16'h005A);

    // ROM read returns the low address byte from the model
    access("rom_rd", 16'hFFFC, 1'b0, 8'h00, rd);
    check("rom_rd_addr", 16'(rom_address), 16'h3FFC);
    check("rom_rd_data", 16'(rd),          16'h00FC);

    // LED register
    access("led_wr", 16'h4000, 1'b1, 8'hA5, rd);
    check("led_val", 16'(leds), 16'h00A5);
    access("led_rd", 16'h4000, 1'b0, 8'h00, rd);
    check("led_rd_data", 16'(rd), 16'h00A5);

    // ROM write is dropped
    w0 = we_count;
    access("rom_wr", 16'hC000, 1'b1, 8'h11, rd);
    check("rom_wr_no_strobe", 16'(we_count - w0), 16'd0);
    check("rom_wr_leds",      16'(leds),          16'h00A5);
`ifdef MEMORY_BUS_TRAP_EN
    check("rom_wr_err", 16'(bus_error), 16'h1);
    access("err_clr0", 16'h4004, 1'b1, 8'h00, rd);
    check("err_clr0_val", 16'(bus_error), 16'h0);
`else
    check("rom_wr_err", 16'(bus_error), 16'h0);
`endif

    // Buttons through the synchronizer
    buttons = 4'b1010;
    repeat (3) @(negedge clk);
    access("btn_rd", 16'h4001, 1'b0, 8'h00, rd);
    check("btn_rd_data", 16'(rd), 16'h000A);

    // Tick: clear, then atomic low/high read (cleared at E+1, sampled 5 edges later)
    access("tick_clr", 16'h4002, 1'b1, 8'h00, rd);
    access("tick_lo", 16'h4002, 1'b0, 8'h00, rd);
    check("tick_lo_data", 16'(rd), 16'h0004);
    access("tick_hi", 16'h4003, 1'b0, 8'h00, rd);
    check("tick_hi_data", 16'(rd), 16'h0000);

    // Unmapped access
    access("unm_rd", 16'h2000, 1'b0, 8'h00, rd);
    check("unm_rd_data", 16'(rd), 16'h00FF);
`ifdef MEMORY_BUS_TRAP_EN
    check("unm_err_set", 16'(bus_error), 16'h1);
    access("err_rd", 16'h4004, 1'b0, 8'h00, rd);
    check("err_rd_data", 16'(rd), 16'h0001);
    access("err_clr", 16'h4004, 1'b1, 8'h5C, rd);
    check("err_clr_val", 16'(bus_error), 16'h0);
`else
    check("unm_err_tied", 16'(bus_error), 16'h0);
    access("err_rd", 16'h4004, 1'b0, 8'h00, rd);
    check("err_rd_data", 16'(rd), 16'h00FF);
`endif

    // Handshake: enable held after done must not start a second access
    w0 = we_count;
    start_req(16'h0300, 1'b1, 8'h33);
    wait_done(lat);
    check("hs_lat", 16'(lat), 16'd2);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!cpu_bus_done) ok = 1'b0;
    end
    check("hs_done_held",  16'(ok),            16'h1);
    check("hs_one_strobe", 16'(we_count - w0), 16'd1);
    end_req("hs");
    access("hs_rd", 16'h0300, 1'b0, 8'h00, rd);
    check("hs_rd_data", 16'(rd), 16'h0033);

    // Reset during the ACCESS cycle of a RAM write
    w0 = we_count;
    start_req(16'h0200, 1'b1, 8'h77);
    @(posedge clk);
    @(negedge clk);
    check("mid_we_high", 16'(ram_write_enable), 16'h1);
    reset = 1'b1;
    #1;
    check("mid_we_masked", 16'(ram_write_enable), 16'h0);
    @(negedge clk);
    check("mid_done",    16'(cpu_bus_done),      16'h0);
    check("mid_leds",    16'(leds),              16'h0);
    check("mid_dout",    16'(cpu_data_out),      16'h0);
    check("mid_we_after",16'(ram_write_enable),  16'h0);
    check("mid_no_write",16'(we_count - w0),     16'd0);
    cpu_bus_enable = 1'b0;
    reset          = 1'b0;
    @(negedge clk);
    access("post_rst_rd", 16'h0200, 1'b0, 8'h00, rd);
    check("post_rst_data", 16'(rd), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/memory_bus.md
Name: memory_bus

Overview:
- CPU-side memory bus controller that sits directly upstream of the on-chip 1 KiB RAM and the program ROM.
- Decodes the 16-bit 6502 address and drives the RAM and ROM ports.
- Absorbs their 1-cycle synchronous read latency behind a four-phase enable/done handshake.
- Hosts a small memory-mapped peripheral page (LEDs, buttons, tick counter).

Parameters:
- TICK_WIDTH, 16, width of free-running tick counter (8..16)
- UNMAPPED_VALUE, 8'hff, read data returned for unmapped addresses

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_address  input  16  CPU byte address
- cpu_data_in  input  8  CPU write data
- cpu_data_out  output  8  read data to CPU
- cpu_bus_enable  input  1  CPU request; held high until cpu_bus_done seen
- cpu_write  input  1  1=write, 0=read; sampled with request
- cpu_bus_done  output  1  transaction complete; held until cpu_bus_enable low
- ram_address  output  10  RAM address
- ram_data_in  output  8  RAM write data
- ram_data_out  input  8  RAM registered read data
- ram_write_enable  output  1  RAM write strobe
- rom_address  output  14  ROM address
- rom_data_out  input  8  ROM registered read data
- leds  output  8  LED register
- buttons  input  4  raw asynchronous button inputs
- bus_error  output  1  sticky unmapped-access flag (see Optional Feature)

Behaviour:
- Memory map:
  - 0x0000-0x03FF RAM.
  - 0x4000 LED reg (R/W).
  - 0x4001 buttons (R, {4'b0,sync_buttons}).
  - 0x4002 tick low (R; write clears counter).
  - 0x4003 tick high (R).
  - 0x4004 error reg.
  - 0xC000-0xFFFF ROM (rom_address = cpu_address[13:0]; writes dropped).
  - All else unmapped: reads return UNMAPPED_VALUE, writes dropped.
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE:
  - On a clock edge E with cpu_bus_enable=1: latch address, write data and cpu_write; register ram_address/rom_address from cpu_address.
  - Next state ACCESS.
  - Requests are never accepted outside IDLE.
- ACCESS (cycle after E):
  - Write to RAM: ram_write_enable=1 for exactly this cycle, ram_data_in=latched data.
  - Write to a peripheral: the register update takes effect at edge E+1.
  - Read: RAM/ROM registers its output at edge E+1.
  - Next state CAPTURE.
- CAPTURE:
  - At edge E+2, cpu_data_out is loaded from the selected source. Writes leave cpu_data_out unchanged.
  - cpu_bus_done=1 from E+2 onward; next state DONE.
  - All accesses have uniform latency: done visible 2 cycles after acceptance.
- DONE: hold cpu_bus_done=1 and cpu_data_out stable; when cpu_bus_enable=0 at an edge, done drops and state goes to IDLE.
- Minimum back-to-back spacing: 4 cycles.
- ram_write_enable is 0 in every state except the ACCESS of a RAM write.
- Buttons: 2-flop synchronizer; the read value is the synchronized value.
- Tick counter:
  - Increments every cycle and wraps from all-ones to 0.
  - Reading 0x4002 snapshots the upper byte into a holding register; reading 0x4003 returns the holding register, giving an atomic 16-bit read.
  - If TICK_WIDTH<16, the upper bits read as 0.
  - A write to 0x4002 clears the counter to 0 at edge E+1; increment resumes from 0 the following edge.
- Reset (also mid-transaction): state IDLE; cpu_bus_done=0, cpu_data_out=0, ram_write_enable=0, ram_address=0, rom_address=0, ram_data_in=0, leds=0, tick=0, holding=0, synchronizer=0, bus_error=0. Any in-flight write is discarded if reset coincides with ACCESS.

Optional Feature:
- MEMORY_BUS_TRAP_EN defined:
  - Any access to an unmapped address sets bus_error at edge E+1; it stays sticky.
  - A write of any value to 0x4004 clears it.
  - Reading 0x4004 returns {7'b0,bus_error}.
  - A ROM write also counts as unmapped.
- MEMORY_BUS_TRAP_EN undefined:
  - bus_error is tied 0.
  - 0x4004 is treated as unmapped: reads return UNMAPPED_VALUE, writes dropped.
  - ROM writes are silently dropped.

Test Plan:
- RAM write/read: write 0x5A to 0x0123, then read 0x0123 -> ram_write_enable high exactly 1 cycle with ram_address=0x123; read returns 0x5A, done 2 cycles after acceptance.
- ROM read: rom_data_out model returns address-low-byte; read 0xFFFC -> rom_address=0x3FFC, cpu_data_out=0xFC; write 0x11 to 0xC000 -> no RAM strobe, leds unchanged.
- Peripherals: write 0xA5 to 0x4000 -> leds=0xA5; buttons=4'b1010 held 3 cycles, read 0x4001 -> 0x0A; write 0x4002 then read 0x4002/0x4003 -> small counter value, high byte consistent with snapshot.
- Handshake: hold cpu_bus_enable high 10 cycles after done -> done stays high, no second access; drop enable -> done low next edge, new request accepted.
- Unmapped: read 0x2000 -> 0xFF; with MEMORY_BUS_TRAP_EN bus_error=1, read 0x4004 -> 0x01, write 0x4004 -> bus_error=0.
- Reset mid-write: assert reset during ACCESS of a RAM write -> ram_write_enable=0 that edge onward, done=0, leds=0, state accepts a new request after reset releases.
